// File: rtl/br_resolve.sv
// Execute-stage branch resolution: evaluates the condition, computes target/fall-through,
// checks the fetch prediction and holds one registered result. Optional counters: BR_STATS_EN.
module br_resolve #(
    parameter int WIDTH      = 32,
    parameter int INST_BYTES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [3:0]       br_type,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    input  logic             pred_taken,
    input  logic [WIDTH-1:0] pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt,
    input  logic             stat_clr
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    logic             cond;
    logic             rs1_neg;
    logic             rs1_zero;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] fallthru;
    logic             next_mis;
    logic             accept;

    assign rs1_neg  = rs1[WIDTH-1];
    assign rs1_zero = (rs1 == '0);
    assign target   = pc + imm;
    assign fallthru = pc + WIDTH'(INST_BYTES);

    always_comb begin
        cond = 1'b0;
        case (br_type)
            4'd1:    cond = (rs1 == rs2);
            4'd2:    cond = (rs1 != rs2);
            4'd3:    cond = rs1_neg;
            4'd4:    cond = !rs1_neg && !rs1_zero;
            4'd5:    cond = !rs1_neg;
            4'd6:    cond = rs1_neg || rs1_zero;
            4'd7:    cond = ($signed(rs1) <  $signed(rs2));
            4'd8:    cond = ($signed(rs1) >= $signed(rs2));
            4'd9:    cond = (rs1 <  rs2);
            4'd10:   cond = (rs1 >= rs2);
            4'd11:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // Target is only compared when both resolved and predicted directions are taken.
    assign next_mis = (cond != pred_taken) || (cond && pred_taken && (target != pred_target));

    // Handshake: a transfer happens on any edge where valid && ready; in_ready depends only
    // on out_valid and out_ready, so a drain and a load can share one edge.
    assign in_ready  = (state == EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            taken       <= 1'b0;
            redirect_pc <= '0;
            mispredict  <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (accept) begin
            state       <= FULL;
            taken       <= cond;
            redirect_pc <= cond ? target : fallthru;
            mispredict  <= next_mis;
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end

`ifdef BR_STATS_EN
    logic             out_fire;
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] mis_q;

    assign out_fire = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q  <= '0;
            mis_q <= '0;
        end else if (stat_clr) begin
            br_q  <= '0;
            mis_q <= '0;
        end else if (out_fire) begin
            if (br_q != '1)
                br_q <= br_q + 1'b1;
            if (mispredict && (mis_q != '1))
                mis_q <= mis_q + 1'b1;
        end
    end

    assign br_cnt  = br_q;
    assign mis_cnt = mis_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign br_cnt  = '0;
    assign mis_cnt = '0;
`endif

endmodule
